// File: rtl/mips_decode_exec_pkg.sv
// Shared constants for the decode/execute slice: opcodes, R-type funct codes
// and the ALU operation codes produced by the controller.
package mips_decode_exec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_decode_exec_if.sv
// Bundle of decode, register-file and ALU signals between the slice and its user.
// slave is the design side, master the driving side.
interface mips_decode_exec_if #(parameter int DATA_WIDTH = 32);
  logic [5:0]            op;
  logic [5:0]            funct;
  logic                  branch, jump, regdst, alusrc;
  logic                  memwrite, memread, memtoreg, regwrite, flush;
  logic [2:0]            alucont;
  logic                  we;
  logic [4:0]            ra1, ra2, wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic [DATA_WIDTH-1:0] a, b;
  logic [2:0]            aluctl;
  logic [DATA_WIDTH-1:0] result;

  modport slave (
    input  op, funct, we, ra1, ra2, wa, wd, a, b, aluctl,
    output branch, jump, regdst, alusrc, memwrite, memread, memtoreg,
           regwrite, flush, alucont, rd1, rd2, result
  );

  modport master (
    output op, funct, we, ra1, ra2, wa, wd, a, b, aluctl,
    input  branch, jump, regdst, alusrc, memwrite, memread, memtoreg,
           regwrite, flush, alucont, rd1, rd2, result
  );
endinterface

// File: rtl/mips_decode_exec_alu.sv
// Combinational ALU: and/or/add/sub/slt plus inverted-operand variants.
// Overflow is discarded; no flags.
module mips_decode_exec_alu #(parameter int DATA_WIDTH = 32) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            aluctl,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] bb;
  logic [DATA_WIDTH-1:0] sum;
  logic                  slt;

  assign bb  = aluctl[2] ? ~b : b;
  assign sum = a + bb + {{(DATA_WIDTH-1){1'b0}}, aluctl[2]};
  // Compare uses the raw b so both 011 and 111 give a true signed less-than.
  assign slt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (aluctl[1:0])
      2'b00: result = a & bb;
      2'b01: result = a | bb;
      2'b10: result = sum;
      2'b11: result = {{(DATA_WIDTH-1){1'b0}}, slt};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mips_decode_exec_controller.sv
// Main decoder: opcode/funct to datapath control, purely combinational.
// A jump flushes the fetched instruction; branches keep their delay slot.
module mips_decode_exec_controller
  import mips_decode_exec_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       branch,
  output logic       jump,
  output logic       regdst,
  output logic       alusrc,
  output logic       memwrite,
  output logic       memread,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       flush,
  output logic [2:0] alucont
);

  always_comb begin
    branch   = 1'b0;
    jump     = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memwrite = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alucont  = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        alucont  = funct_to_alu(funct);
      end
      OP_LW: begin
        alusrc   = 1'b1;
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        alucont = ALU_SUB;
      end
      OP_ADDI: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      OP_J: jump = 1'b1;
      default: ;
    endcase
  end

  assign flush = jump;

endmodule

// File: rtl/mips_decode_exec_regfile.sv
// 32-entry register file, two combinational read ports, one write port.
// Writes land on the rising edge; a same-cycle read of the written register sees wd.
module mips_decode_exec_regfile #(parameter int DATA_WIDTH = 32) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [4:0]            ra1,
  input  logic [4:0]            ra2,
  input  logic [4:0]            wa,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [DATA_WIDTH-1:0] regs [32];
  logic                  wr_act;

  assign wr_act = we && (wa != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_act) begin
      regs[wa] <= wd;
    end
  end

  // Register 0 is hardwired; the bypass never applies to it because wr_act excludes wa==0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) rd1 = (wr_act && ra1 == wa) ? wd : regs[ra1];
    if (ra2 != 5'd0) rd2 = (wr_act && ra2 == wa) ? wd : regs[ra2];
  end

endmodule

// File: rtl/mips_decode_exec.sv
// Decode/execute slice: controller, register file and ALU wired to one bus.
// Only the register file holds state; everything else is combinational.
module mips_decode_exec
  import mips_decode_exec_pkg::*;
#(parameter int DATA_WIDTH = 32) (
  input logic              clk,
  input logic              reset,
  mips_decode_exec_if.slave bus
);

  mips_decode_exec_controller u_controller (
    .op       (bus.op),
    .funct    (bus.funct),
    .branch   (bus.branch),
    .jump     (bus.jump),
    .regdst   (bus.regdst),
    .alusrc   (bus.alusrc),
    .memwrite (bus.memwrite),
    .memread  (bus.memread),
    .memtoreg (bus.memtoreg),
    .regwrite (bus.regwrite),
    .flush    (bus.flush),
    .alucont  (bus.alucont)
  );

  mips_decode_exec_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (bus.we),
    .ra1   (bus.ra1),
    .ra2   (bus.ra2),
    .wa    (bus.wa),
    .wd    (bus.wd),
    .rd1   (bus.rd1),
    .rd2   (bus.rd2)
  );

  mips_decode_exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (bus.a),
    .b      (bus.b),
    .aluctl (bus.aluctl),
    .result (bus.result)
  );

endmodule

// File: tb/tb_mips_decode_exec.sv
// Randomised bench with a behavioural model of decode table, register file and ALU.
module tb_mips_decode_exec;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_decode_exec_if #(.DATA_WIDTH(32)) bus ();

  mips_decode_exec #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;
  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // {branch,jump,regdst,alusrc,memwrite,memread,memtoreg,regwrite,flush,alucont}
  function automatic logic [11:0] exp_ctl(input logic [5:0] op, input logic [5:0] funct);
    logic [2:0] rc;
    case (funct)
      6'b100000: rc = 3'b010;
      6'b100010: rc = 3'b110;
      6'b100100: rc = 3'b000;
      6'b100101: rc = 3'b001;
      6'b101010: rc = 3'b111;
      default:   rc = 3'b010;
    endcase
    case (op)
      6'b000000: return {9'b001000010, rc};
      6'b100011: return {9'b000101110, 3'b010};
      6'b101011: return {9'b000110000, 3'b010};
      6'b000100: return {9'b100000000, 3'b110};
      6'b001000: return {9'b000100010, 3'b010};
      6'b000010: return {9'b010000001, 3'b010};
      default:   return {9'b000000000, 3'b010};
    endcase
  endfunction

  function automatic logic [31:0] exp_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    case (c)
      3'b010: return a + b;
      3'b110: return a - b;
      3'b000: return a & b;
      3'b001: return a | b;
      3'b100: return a & ~b;
      3'b101: return a | ~b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (bus.we && bus.wa == ra) return bus.wd;
    return model[ra];
  endfunction

  function automatic logic [11:0] dut_ctl();
    return {bus.branch, bus.jump, bus.regdst, bus.alusrc, bus.memwrite, bus.memread,
            bus.memtoreg, bus.regwrite, bus.flush, bus.alucont};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ctl", {20'd0, dut_ctl()}, {20'd0, exp_ctl(bus.op, bus.funct)});
      check("rd1", bus.rd1, exp_rd(bus.ra1));
      check("rd2", bus.rd2, exp_rd(bus.ra2));
      check("alu", bus.result, exp_alu(bus.a, bus.b, bus.aluctl));
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFFFFFF;
      1: return 32'h80000000;
      2: return 32'h7FFFFFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random();
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    bus.op     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
    bus.funct  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
    reset      = ($urandom_range(0, 40) == 0);
    bus.we     = $urandom_range(0, 1) == 1;
    bus.wa     = 5'($urandom_range(0, 7));
    bus.wd     = $urandom;
    bus.ra1    = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 7));
    bus.ra2    = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom);
    bus.a      = rand_operand();
    bus.b      = rand_operand();
    bus.aluctl = 3'($urandom);
  endtask

  // Model state advances with whatever the DUT saw at this edge.
  task automatic edge_step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (bus.we && bus.wa != 5'd0) begin
      model[bus.wa] = bus.wd;
    end
    #1;
  endtask

  initial begin
    bus.op = 6'd0; bus.funct = 6'd0; bus.we = 1'b0;
    bus.ra1 = 5'd0; bus.ra2 = 5'd0; bus.wa = 5'd0; bus.wd = 32'd0;
    bus.a = 32'd0; bus.b = 32'd0; bus.aluctl = 3'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'hDEADBEEF;

    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    bus.ra1 = 5'd5; bus.ra2 = 5'd31;
    #1;
    check("reset_rd1", bus.rd1, 32'd0);
    check("reset_rd2", bus.rd2, 32'd0);

    bus.op = 6'b000000; bus.funct = 6'b101010; #1;
    check("dec_slt", {20'd0, dut_ctl()}, 32'h217);
    bus.op = 6'b000010; #1;
    check("dec_j", {20'd0, dut_ctl()}, 32'h40A);
    bus.op = 6'b001000; bus.funct = 6'b000000; #1;
    check("dec_nop", {20'd0, dut_ctl()}, 32'h112);

    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h12345678; bus.ra2 = 5'd5; #1;
    check("bypass_rd2", bus.rd2, 32'h12345678);
    edge_step();
    bus.we = 1'b0; bus.ra1 = 5'd5; #1;
    check("write_rd1", bus.rd1, 32'h12345678);

    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF; bus.ra1 = 5'd0; #1;
    check("r0_bypass", bus.rd1, 32'd0);
    edge_step();
    bus.we = 1'b0; #1;
    check("r0_read", bus.rd1, 32'd0);

    bus.a = 32'd7; bus.b = 32'd5;
    bus.aluctl = 3'b010; #1; check("alu_add", bus.result, 32'd12);
    bus.aluctl = 3'b110; #1; check("alu_sub", bus.result, 32'd2);
    bus.aluctl = 3'b000; #1; check("alu_and", bus.result, 32'd5);
    bus.aluctl = 3'b001; #1; check("alu_or", bus.result, 32'd7);
    bus.aluctl = 3'b100; #1; check("alu_andn", bus.result, 32'd2);
    bus.aluctl = 3'b101; #1; check("alu_orn", bus.result, 32'hFFFFFFFF);
    bus.a = 32'hFFFFFFFF; bus.b = 32'd1;
    bus.aluctl = 3'b111; #1; check("alu_slt_neg", bus.result, 32'd1);
    bus.aluctl = 3'b011; #1; check("alu_lt_neg", bus.result, 32'd1);
    bus.aluctl = 3'b010; #1; check("alu_add_wrap", bus.result, 32'd0);
    bus.a = 32'd1; bus.b = 32'hFFFFFFFF;
    bus.aluctl = 3'b111; #1; check("alu_slt_pos", bus.result, 32'd0);
    bus.a = 32'd0; bus.b = 32'd1;
    bus.aluctl = 3'b110; #1; check("alu_sub_wrap", bus.result, 32'hFFFFFFFF);

    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h0000AAAA;
    edge_step();
    reset = 1'b1; bus.wd = 32'h5555BBBB;
    edge_step();
    reset = 1'b0; bus.we = 1'b0; bus.ra1 = 5'd3; bus.ra2 = 5'd5; #1;
    check("reset_prio_r3", bus.rd1, 32'd0);
    check("reset_clr_r5", bus.rd2, 32'd0);

    cmp_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      drive_random();
      edge_step();
    end
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_decode_exec.md
MIPS_DECODE_EXEC -- requirements
Module: mips_decode_exec

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width of register file and ALU.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 op  input  6  opcode (instr[31:26]).
REQ-005 funct  input  6  function field (instr[5:0]).
REQ-006 branch, jump, regdst, alusrc, memwrite, memread, memtoreg, regwrite, flush  output  1 each  decoded control signals.
REQ-007 alucont  output  3  ALU operation code.
REQ-008 we  input  1  register write enable.
REQ-009 ra1, ra2, wa  input  5 each  read addresses 1/2, write address.
REQ-010 wd  input  DATA_WIDTH  write data.
REQ-011 rd1, rd2  output  DATA_WIDTH  read data.
REQ-012 a, b  input  DATA_WIDTH  ALU operands.
REQ-013 aluctl  input  3  ALU operation select.
REQ-014 result  output  DATA_WIDTH  ALU result.

Function
REQ-015 Controller combinational; decode table (branch,jump,regdst,alusrc,memwrite,memread,memtoreg,regwrite,alucont):
- R-type 000000: 0,0,1,0,0,0,0,1,from funct
- lw 100011: 0,0,0,1,0,1,1,1,010
- sw 101011: 0,0,0,1,1,0,0,0,010
- beq 000100: 1,0,0,0,0,0,0,0,110
- addi 001000: 0,0,0,1,0,0,0,1,010
- j 000010: 0,1,0,0,0,0,0,0,010
- any other op: all 0, alucont 010.
REQ-016 R-type funct map: 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111; other funct ->010 with regwrite still 1.
REQ-017 flush SHALL equal jump; branches have one delay slot, no flush.
REQ-018 Register file: 32 x DATA_WIDTH; rd1/rd2 combinational reads of ra1/ra2.
REQ-019 Write: on rising clk when we=1 and wa!=0, reg[wa]<=wd; writes to register 0 ignored; register 0 always reads 0.
REQ-020 Write-through bypass: when we=1, wa!=0 and ra==wa, that read port returns wd in the same cycle.
REQ-021 ALU combinational: bb = aluctl[2] ? ~b : b; sum = a + bb + aluctl[2] modulo 2^DATA_WIDTH.
REQ-022 aluctl[1:0]: 00 a&bb, 01 a|bb, 10 sum, 11 signed(a)<signed(b) ? 1 : 0 (zero-extended).
REQ-023 Codes: 010 add, 110 sub, 000 and, 001 or, 111 slt, 100 and-not, 101 or-not, 011 signed less-than; no flags, overflow discarded.

Reset
REQ-024 On rising clk with reset=1 all 32 registers SHALL clear to 0; reset has priority over a simultaneous write.
REQ-025 Controller and ALU outputs are unaffected by reset (pure combinational).

Structure
REQ-026 Shared package holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants and the five alucont codes.
REQ-027 Top instantiates three sub-modules: controller, regfile, alu; no extra logic at top.
REQ-028 NOP encoding 32'h20000000 (addi $0,$0,0) decodes to regwrite=1 with wa 0, so it has no architectural effect.

Verification
REQ-029 op=000000, funct=101010 -> regdst=1, regwrite=1, alucont=111, all others 0; op=000010 -> jump=1, flush=1.
REQ-030 Reset, then we=1, wa=5, wd=0x12345678, edge -> rd1 (ra1=5) = 0x12345678; same cycle, ra2=5 -> bypass value 0x12345678.
REQ-031 we=1, wa=0, wd=0xFFFFFFFF, edge -> ra1=0 reads 0.
REQ-032 ALU: a=7, b=5: 010->12, 110->2, 000->5, 001->7; a=0xFFFFFFFF, b=1, 111->1; a=1, b=0xFFFFFFFF, 111->0.
REQ-033 ALU wrap: a=0xFFFFFFFF, b=1, 010 -> 0; a=0, b=1, 110 -> 0xFFFFFFFF.
REQ-034 reset=1 concurrent with we=1, wa=3 -> register 3 reads 0 after the edge.
